// File: rtl/noobs_mem_arb.sv
// Shares one single-port synchronous RAM between CPU fetch, CPU data and a loader/debug port.
// Loader priority, CPU round-robin, starvation escalation and an exclusive loader lock.
module noobs_mem_arb #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_req,
  input  logic          ld_wr,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold
);

  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [1:0] OWN_IF = 2'd1;
  localparam logic [1:0] OWN_D  = 2'd2;
  localparam logic [1:0] OWN_LD = 2'd3;

  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr;
  logic [3:0]    if_wait, d_wait;
  logic          lock_hold;
  logic          if_starved, d_starved;
  logic          win_if, win_d, win_ld;
  logic          rd_vld_p1;
  logic [1:0]    rd_own_p1;
  logic [DW-1:0] if_hold, d_hold, ld_hold;

  function automatic logic [3:0] wait_next(input logic req, input logic gnt,
                                           input logic [3:0] cnt);
    if (!req || gnt)     return 4'd0;
    else if (cnt >= LIMIT) return LIMIT;
    else                 return cnt + 4'd1;
  endfunction

  // Lock only holds while the loader keeps ld_lock up; the release cycle arbitrates normally.
  assign lock_hold  = (state == LOCKED) && ld_lock;
  assign if_starved = if_req && (if_wait == LIMIT);
  assign d_starved  = d_req && (d_wait == LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_) state <= NORMAL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == LOCKED) begin
      if (!ld_lock) state_nxt = NORMAL;
    end else if (win_ld && ld_lock) begin
      state_nxt = LOCKED;
    end
  end

  always_comb begin
    win_if = 1'b0;
    win_d  = 1'b0;
    win_ld = 1'b0;
    if (reset_) begin
      if (lock_hold)                       win_ld = ld_req;
      else if (d_starved)                  win_d  = 1'b1;
      else if (if_starved)                 win_if = 1'b1;
      else if (ld_req)                     win_ld = 1'b1;
      else if (d_req && (!rr_ptr || !if_req)) win_d = 1'b1;
      else if (if_req)                     win_if = 1'b1;
    end
    if_gnt    = win_if;
    d_gnt     = win_d;
    ld_gnt    = win_ld;
    mem_en    = win_if | win_d | win_ld;
    mem_wr    = (win_d & d_wr) | (win_ld & ld_wr);
    mem_addr  = win_d ? d_addr : win_ld ? ld_addr : win_if ? if_addr : '0;
    mem_wdata = win_d ? d_wdata : win_ld ? ld_wdata : '0;
    cpu_hold  = reset_ && (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      rr_ptr  <= 1'b0;
      if_wait <= 4'd0;
      d_wait  <= 4'd0;
    end else begin
      if (win_if || win_d) rr_ptr <= win_d;
      if (!lock_hold) begin
        if_wait <= wait_next(if_req, win_if, if_wait);
        d_wait  <= wait_next(d_req, win_d, d_wait);
      end
    end
  end

  // p0 -> p1: remember who owns the read data returning next cycle
  always_ff @(posedge clk) begin
    if (!reset_) begin
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= 2'd0;
      if_hold   <= '0;
      d_hold    <= '0;
      ld_hold   <= '0;
    end else begin
      rd_vld_p1 <= mem_en && !mem_wr;
      rd_own_p1 <= win_d ? OWN_D : win_ld ? OWN_LD : OWN_IF;
      if (if_rvalid) if_hold <= mem_rdata;
      if (d_rvalid)  d_hold  <= mem_rdata;
      if (ld_rvalid) ld_hold <= mem_rdata;
    end
  end

  assign if_rvalid = reset_ && rd_vld_p1 && (rd_own_p1 == OWN_IF);
  assign d_rvalid  = reset_ && rd_vld_p1 && (rd_own_p1 == OWN_D);
  assign ld_rvalid = reset_ && rd_vld_p1 && (rd_own_p1 == OWN_LD);
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_hold;
  assign ld_rdata  = ld_rvalid ? mem_rdata : ld_hold;

endmodule

// File: doc/noobs_mem_arb.md
Name: noobs_mem_arb

Overview:
- Arbiter/sequencer that shares one single-port synchronous 4K x 8 RAM between three requesters:
  - the CPU instruction fetch port (i_addr/i_data);
  - the CPU data port (m_addr/m_rd/m_wr);
  - a loader/debug port used to preload programs or inspect memory.
- Sits between noobs_cpu and the unified RAM.
- Resolves conflicts with loader priority, CPU round-robin, starvation escalation and an exclusive loader lock.

Parameters:
- AW, 12, memory address width.
- DW, 8, data width.
- STARVE_LIMIT, 4, consecutive denied cycles after which a CPU requester is escalated above the loader; legal range 1..15.

Ports:
- clk  input  1  clock
- reset_  input  1  synchronous active-low reset
- if_req  input  1  instruction read request
- if_addr  input  AW  instruction address
- if_gnt  output  1  instruction request accepted this cycle
- if_rvalid  output  1  if_rdata valid
- if_rdata  output  DW  instruction read data
- d_req  input  1  data request
- d_wr  input  1  1=write, 0=read
- d_addr  input  AW  data address
- d_wdata  input  DW  data write data
- d_gnt  output  1  data request accepted
- d_rvalid  output  1  d_rdata valid
- d_rdata  output  DW  data read data
- ld_req  input  1  loader request
- ld_wr  input  1  1=write, 0=read
- ld_lock  input  1  request exclusive ownership
- ld_addr  input  AW  loader address
- ld_wdata  input  DW  loader write data
- ld_gnt  output  1  loader request accepted
- ld_rvalid  output  1  ld_rdata valid
- ld_rdata  output  DW  loader read data
- mem_en  output  1  RAM enable
- mem_wr  output  1  RAM write strobe
- mem_addr  output  AW  RAM address
- mem_wdata  output  DW  RAM write data
- mem_rdata  input  DW  RAM read data, valid cycle after mem_en with mem_wr=0
- cpu_hold  output  1  high while loader owns memory exclusively

Behaviour:

Clock and reset:
- Single clock (clk); reset is synchronous, active-low (reset_).
- Reset values: all gnt/rvalid = 0; mem_en = mem_wr = 0; mem_addr/mem_wdata = 0; rdata outputs = 0; cpu_hold = 0.
- Reset also sets state = NORMAL, rr_ptr = 0 (data port preferred first) and both wait counters = 0.

Handshake:
- Requester holds req/wr/addr/wdata stable until it sees gnt.
- gnt is combinational in the cycle the request wins; at most one gnt per cycle.
- mem_* are driven combinationally from the winner. With no winner: mem_en = 0 and mem_wr = 0.
- Read latency is 1: the winner's rvalid pulses exactly 1 cycle after a read grant, with rdata = mem_rdata.
- rdata holds its last value otherwise. Writes never produce rvalid.
- The return-owner register (2-bit id + valid) is pipelined, so back-to-back reads from different ports are returned correctly.
- if port is read-only.

State machine (2 states):
- NORMAL, priority order:
  1. A starved CPU port (wait counter == STARVE_LIMIT). If both are starved, data wins.
  2. Loader.
  3. Round-robin between if and d: rr_ptr=0 prefers d, rr_ptr=1 prefers if.
- rr_ptr toggles to prefer the other CPU port after every CPU grant. It is unchanged on loader grants.
- NORMAL -> LOCKED when ld is granted while ld_lock = 1.
- LOCKED:
  - Only ld may be granted; if/d are never granted.
  - cpu_hold = 1 (registered, from the cycle after lock entry).
  - LOCKED -> NORMAL on the first cycle ld_lock = 0. That cycle already arbitrates as NORMAL.
  - cpu_hold falls the following cycle.

Wait counters (per CPU port, 4-bit):
- Increment on req && !gnt, saturating at STARVE_LIMIT.
- Clear on gnt or !req.
- Counters do not increment in LOCKED; they hold.

Boundary cases:
- Simultaneous requests from all three ports with no starvation -> ld wins.
- Reset mid-read: the pending rvalid is dropped; no rvalid the cycle after reset release.
- Reset while LOCKED -> NORMAL, cpu_hold = 0.
- Address passes through unmodified; no wrap logic is needed (AW-bit address).

Test Plan:
- Reset with all req=1 -> all gnt/rvalid/mem_en = 0 while reset_=0. First cycle after release: ld_gnt=1, and ld_rvalid=1 next cycle if ld_wr=0.
- if_req and d_req held continuously, ld idle, RAM preloaded mem[0x010]=0xA5 and mem[0x800]=0x3C, if_addr=0x010, d_addr=0x800 read -> grants alternate d,if,d,if; rvalid on the matching port 1 cycle later with 0x3C / 0xA5.
- ld write 0x5A to 0x123, then d read 0x123 -> d_rvalid=1 with d_rdata=0x5A exactly 1 cycle after d_gnt; no rvalid for the write.
- ld_req=1 continuously (no lock), d_req=1, STARVE_LIMIT=4 -> d denied 4 cycles, d_gnt=1 on the 5th cycle, then ld regains the grant.
- ld_lock=1 with ld granted for 10 cycles while if_req=1 -> if_gnt=0 throughout, cpu_hold=1 from the next cycle; drop ld_lock -> if_gnt=1 in that same cycle, cpu_hold=0 the cycle after.
- d read granted in cycle N, reset_=0 in cycle N+1 -> d_rvalid stays 0 and state is NORMAL after release.
